control_sequencer: RTL
======================

CONTROL_SEQUENCER -- requirements
Module: control_sequencer

Interface
REQ-001 The block SHALL have one clock; reset is synchronous and active-low.
REQ-002 Ports SHALL be (name direction width meaning), clock and reset first:
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous active-low reset
- run  in  1  1 = sequencer may start a new fetch
- mem_ready  in  1  memory read data valid this cycle
- dec_nop  in  1  decoder: nop
- dec_single  in  1  decoder: any single-cycle op (add_s, sub_s, and_s, shl, shr, clr_s, psah, outb, outs, all mov_*)
- dec_muldiv  in  1  decoder: mul_s or div_s
- dec_load  in  1  decoder: load
- dec_jmp  in  1  decoder: jmp
- dec_jz  in  1  decoder: jz
- dec_jge  in  1  decoder: jge
- zero_flag  in  1  ALU zero flag
- neg_flag  in  1  ALU sign flag
- alu_done  in  1  mul/div unit completion pulse
- mar_ld  out  1  load MAR from PC
- mem_rd  out  1  memory read request
- ir_ld  out  1  load instruction register
- pc_inc  out  1  increment PC
- pc_load  out  1  load PC from memory data bus
- acc_ld  out  1  load accumulator from memory data bus
- exec_en  out  1  qualifies decoder strobes into the datapath
- alu_start  out  1  start mul/div unit
- busy  out  1  instruction in progress
- illegal  out  1  sticky: opcode decoded to no class
- md_timeout  out  1  sticky: mul/div did not complete
- state  out  3  current state encoding

Function
REQ-003 State encodings SHALL be FETCH_A=0, FETCH_M=1, DECODE=2, EXEC=3, MD_START=4, MD_WAIT=5, OPND_A=6, OPND_M=7.
REQ-004 All outputs except state, busy, illegal and md_timeout SHALL be Moore/Mealy single-cycle pulses, 0 in every state not listed for them.
REQ-005 FETCH_A: if run=1, mar_ld=1 and go to FETCH_M; if run=0, stay, mar_ld=0, busy=0.
REQ-006 FETCH_M: mem_rd=1; on mem_ready=1, ir_ld=1, pc_inc=1, go to DECODE; otherwise stay (unbounded wait).
REQ-007 DECODE: one cycle, no strobes; next state by priority dec_muldiv > (dec_jmp|dec_jz|dec_jge) > dec_load > dec_single > dec_nop.
REQ-008 DECODE targets: muldiv -> MD_START; jump/load -> OPND_A; single -> EXEC; nop -> FETCH_A; no class input high -> set illegal, go to FETCH_A.
REQ-009 EXEC: exec_en=1 for exactly one cycle, then FETCH_A.
REQ-010 MD_START: alu_start=1 and exec_en=1 for one cycle, clear 4-bit wait counter, go to MD_WAIT.
REQ-011 MD_WAIT: on alu_done=1 go to FETCH_A; else increment counter; at counter=15 without alu_done set md_timeout and go to FETCH_A (16 wait cycles max).
REQ-012 OPND_A: mar_ld=1, go to OPND_M.
REQ-013 OPND_M: mem_rd=1; on mem_ready=1 go to FETCH_A with: load -> acc_ld=1, pc_inc=1; jmp -> pc_load=1; jz -> pc_load=zero_flag; jge -> pc_load=~neg_flag; untaken jump -> pc_inc=1.
REQ-014 pc_load and pc_inc SHALL never be 1 in the same cycle.
REQ-015 Flags SHALL be sampled in the OPND_M cycle where mem_ready=1.
REQ-016 Instruction class SHALL be latched in DECODE; decoder inputs are ignored in other states.
REQ-017 busy SHALL be 1 in every state except FETCH_A with run=0.
REQ-018 run=0 SHALL only take effect in FETCH_A; an instruction in progress completes.
REQ-019 Latency (mem_ready immediate): nop 3 cycles, single 4, load/jump 5, muldiv 5 + wait cycles.

Reset
REQ-020 rst_n=0 at a clock edge SHALL force state=FETCH_A, clear counter, illegal=0, md_timeout=0, all pulse outputs 0, from any state including mid-wait.
REQ-021 illegal and md_timeout SHALL clear only on reset.

Verification
REQ-022 Bench SHALL cover:
- run=1, mem_ready=1, dec_single -> state 0,1,2,3,0; ir_ld+pc_inc in cycle 2, exec_en in cycle 4 only.
- dec_jz, zero_flag=1 -> pc_load=1, pc_inc=0 in OPND_M; zero_flag=0 -> pc_inc=1, pc_load=0.
- dec_muldiv, alu_done after 3 wait cycles -> alu_start 1 cycle, return to FETCH_A, md_timeout=0; alu_done never -> md_timeout=1 after 16 MD_WAIT cycles.
- all dec_* =0 in DECODE -> illegal=1, stays 1 over next instructions until rst_n=0.
- mem_ready held 0 for 5 cycles in FETCH_M -> mem_rd held 1, no ir_ld until ready.
- rst_n=0 during MD_WAIT -> next cycle state=0, all outputs 0; run=0 -> busy=0, state holds 0.

Source files
------------

// File: rtl/control_sequencer.sv
// Multi-cycle instruction sequencer: fetch, decode and operand/mul-div handling
// for a single-accumulator CPU. Strobes are decoded from the current state and inputs.
module control_sequencer (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       mem_ready,
  input  logic       dec_nop,
  input  logic       dec_single,
  input  logic       dec_muldiv,
  input  logic       dec_load,
  input  logic       dec_jmp,
  input  logic       dec_jz,
  input  logic       dec_jge,
  input  logic       zero_flag,
  input  logic       neg_flag,
  input  logic       alu_done,
  output logic       mar_ld,
  output logic       mem_rd,
  output logic       ir_ld,
  output logic       pc_inc,
  output logic       pc_load,
  output logic       acc_ld,
  output logic       exec_en,
  output logic       alu_start,
  output logic       busy,
  output logic       illegal,
  output logic       md_timeout,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    FETCH_A  = 3'd0,
    FETCH_M  = 3'd1,
    DECODE   = 3'd2,
    EXEC     = 3'd3,
    MD_START = 3'd4,
    MD_WAIT  = 3'd5,
    OPND_A   = 3'd6,
    OPND_M   = 3'd7
  } state_t;

  typedef enum logic [1:0] {
    OP_LOAD = 2'd0,
    OP_JMP  = 2'd1,
    OP_JZ   = 2'd2,
    OP_JGE  = 2'd3
  } opnd_t;

  state_t     cur;
  opnd_t      opnd_cls;
  logic [3:0] wait_cnt;
  logic       jump_taken;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cur        <= FETCH_A;
      opnd_cls   <= OP_LOAD;
      wait_cnt   <= 4'd0;
      illegal    <= 1'b0;
      md_timeout <= 1'b0;
    end else begin
      unique case (cur)
        FETCH_A: if (run) cur <= FETCH_M;
        FETCH_M: if (mem_ready) cur <= DECODE;
        DECODE: begin
          // Jumps outrank load; among jumps jmp > jz > jge
          if (dec_muldiv) begin
            cur <= MD_START;
          end else if (dec_jmp || dec_jz || dec_jge) begin
            cur      <= OPND_A;
            opnd_cls <= dec_jmp ? OP_JMP : (dec_jz ? OP_JZ : OP_JGE);
          end else if (dec_load) begin
            cur      <= OPND_A;
            opnd_cls <= OP_LOAD;
          end else if (dec_single) begin
            cur <= EXEC;
          end else if (dec_nop) begin
            cur <= FETCH_A;
          end else begin
            illegal <= 1'b1;
            cur     <= FETCH_A;
          end
        end
        EXEC: cur <= FETCH_A;
        MD_START: begin
          wait_cnt <= 4'd0;
          cur      <= MD_WAIT;
        end
        MD_WAIT: begin
          if (alu_done) begin
            cur <= FETCH_A;
          end else if (wait_cnt == 4'd15) begin
            md_timeout <= 1'b1;
            cur        <= FETCH_A;
          end else begin
            wait_cnt <= wait_cnt + 4'd1;
          end
        end
        OPND_A: cur <= OPND_M;
        OPND_M: if (mem_ready) cur <= FETCH_A;
        default: cur <= FETCH_A;
      endcase
    end
  end

  always_comb begin
    unique case (opnd_cls)
      OP_JMP:  jump_taken = 1'b1;
      OP_JZ:   jump_taken = zero_flag;
      OP_JGE:  jump_taken = ~neg_flag;
      default: jump_taken = 1'b0;
    endcase
  end

  // Strobes held low while reset is asserted so nothing reaches the datapath
  always_comb begin
    mar_ld    = 1'b0;
    mem_rd    = 1'b0;
    ir_ld     = 1'b0;
    pc_inc    = 1'b0;
    pc_load   = 1'b0;
    acc_ld    = 1'b0;
    exec_en   = 1'b0;
    alu_start = 1'b0;
    if (rst_n) begin
      unique case (cur)
        FETCH_A: mar_ld = run;
        FETCH_M: begin
          mem_rd = 1'b1;
          ir_ld  = mem_ready;
          pc_inc = mem_ready;
        end
        EXEC: exec_en = 1'b1;
        MD_START: begin
          alu_start = 1'b1;
          exec_en   = 1'b1;
        end
        OPND_A: mar_ld = 1'b1;
        OPND_M: begin
          mem_rd = 1'b1;
          if (mem_ready) begin
            if (opnd_cls == OP_LOAD) begin
              acc_ld = 1'b1;
              pc_inc = 1'b1;
            end else begin
              pc_load = jump_taken;
              pc_inc  = ~jump_taken;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign busy  = !((cur == FETCH_A) && !run);
  assign state = cur;

endmodule
